// File: rtl/unified_buffer_port_arbiter_pkg.sv
// Shared types and constants for the unified buffer port arbiter.
// ub_req_e names the requester granted each cycle and doubles as the burst-lock encoding.
package unified_buffer_port_arbiter_pkg;

  localparam int unsigned UB_ADDR_W = 12;
  localparam int unsigned UB_DATA_W = 256;

  typedef enum logic [1:0] {
    UB_REQ_NONE,
    UB_REQ_RD,
    UB_REQ_WB,
    UB_REQ_HOST
  } ub_req_e;

endpackage

// File: rtl/unified_buffer_port_arbiter_rd_valid_pipe.sv
// Shift register that follows each RD command through the SRAM read latency.
// The active-low clear drops every read still in flight.
module ub_rd_valid_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic v_i,
  output logic v_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = v_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign v_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/unified_buffer_port_arbiter.sv
// Shares the single-port UB SRAM between RD (absolute priority), WB and HOST.
// WB and HOST alternate round-robin and hold a lock for the length of a burst.
module unified_buffer_port_arbiter
  import unified_buffer_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = UB_ADDR_W,
  parameter int unsigned DATA_W     = UB_DATA_W,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wb_valid_i,
  input  logic              wb_last_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic              host_valid_i,
  input  logic              host_last_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ready_o,
  output logic              ub_en_o,
  output logic              ub_we_o,
  output logic [ADDR_W-1:0] ub_addr_o,
  output logic [DATA_W-1:0] ub_wdata_o,
  input  logic [DATA_W-1:0] ub_rdata_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              starve_o
);

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);
  localparam logic [7:0] CntSat    = 8'hFF;

  ub_req_e           gnt;
  ub_req_e           lock_q, lock_d;
  ub_req_e           rr_last_q, rr_last_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wb_cnt_q, wb_cnt_d;
  logic [7:0]        host_cnt_q, host_cnt_d;
  logic              starve_q, starve_d;
  logic              rd_valid;

  always_comb begin
    gnt = UB_REQ_NONE;
    if (rd_en_i) begin
      gnt = UB_REQ_RD;
    end else begin
      unique case (lock_q)
        UB_REQ_WB:   if (wb_valid_i) gnt = UB_REQ_WB;
        UB_REQ_HOST: if (host_valid_i) gnt = UB_REQ_HOST;
        default: begin
          if (wb_valid_i && host_valid_i) begin
            gnt = (rr_last_q == UB_REQ_HOST) ? UB_REQ_WB : UB_REQ_HOST;
          end else if (wb_valid_i) begin
            gnt = UB_REQ_WB;
          end else if (host_valid_i) begin
            gnt = UB_REQ_HOST;
          end
        end
      endcase
    end

    lock_d    = lock_q;
    rr_last_d = rr_last_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (gnt)
      UB_REQ_RD: begin
        en_d   = 1'b1;
        addr_d = rd_addr_i;
      end
      UB_REQ_WB: begin
        en_d      = 1'b1;
        we_d      = 1'b1;
        addr_d    = wb_addr_i;
        wdata_d   = wb_data_i;
        rr_last_d = UB_REQ_WB;
        lock_d    = wb_last_i ? UB_REQ_NONE : UB_REQ_WB;
      end
      UB_REQ_HOST: begin
        en_d      = 1'b1;
        we_d      = 1'b1;
        addr_d    = host_addr_i;
        wdata_d   = host_data_i;
        rr_last_d = UB_REQ_HOST;
        lock_d    = host_last_i ? UB_REQ_NONE : UB_REQ_HOST;
      end
      default: ;
    endcase

    // Wait counters saturate; starve_o is sticky once either one reaches the threshold.
    wb_cnt_d = wb_cnt_q;
    if (gnt == UB_REQ_WB) begin
      wb_cnt_d = '0;
    end else if (wb_valid_i && wb_cnt_q != CntSat) begin
      wb_cnt_d = wb_cnt_q + 8'd1;
    end
    host_cnt_d = host_cnt_q;
    if (gnt == UB_REQ_HOST) begin
      host_cnt_d = '0;
    end else if (host_valid_i && host_cnt_q != CntSat) begin
      host_cnt_d = host_cnt_q + 8'd1;
    end
    starve_d = starve_q || (wb_cnt_d >= StarveMax) || (host_cnt_d >= StarveMax);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lock_q     <= UB_REQ_NONE;
      rr_last_q  <= UB_REQ_HOST;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_cnt_q   <= '0;
      host_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      rr_last_q  <= rr_last_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_cnt_q   <= wb_cnt_d;
      host_cnt_q <= host_cnt_d;
      starve_q   <= starve_d;
    end
  end

  ub_rd_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_valid_pipe (
    .clk_i (clk_i),
    .clr_ni(rst_i),
    .v_i   (en_q & ~we_q),
    .v_o   (rd_valid)
  );

  assign wb_ready_o   = (gnt == UB_REQ_WB);
  assign host_ready_o = (gnt == UB_REQ_HOST);
  assign ub_en_o      = en_q;
  assign ub_we_o      = we_q;
  assign ub_addr_o    = addr_q;
  assign ub_wdata_o   = wdata_q;
  assign rd_valid_o   = rd_valid;
  assign rd_data_o    = rd_valid ? ub_rdata_i : '0;
  assign starve_o     = starve_q;

endmodule

// File: tb/tb_unified_buffer_port_arbiter.sv
// Scoreboard bench: the driver pushes hand-derived SRAM commands and read returns,
// and a negedge monitor pops and compares them as the arbiter presents them.
module tb_unified_buffer_port_arbiter;
  import unified_buffer_port_arbiter_pkg::*;

  localparam int RdLat = 2;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [255:0] data;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } rd_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         rd_en_i = 1'b0;
  logic [11:0]  rd_addr_i = '0;
  logic         wb_valid_i = 1'b0;
  logic         wb_last_i = 1'b0;
  logic [11:0]  wb_addr_i = '0;
  logic [255:0] wb_data_i = '0;
  logic         wb_ready_o;
  logic         host_valid_i = 1'b0;
  logic         host_last_i = 1'b0;
  logic [11:0]  host_addr_i = '0;
  logic [255:0] host_data_i = '0;
  logic         host_ready_o;
  logic         ub_en_o;
  logic         ub_we_o;
  logic [11:0]  ub_addr_o;
  logic [255:0] ub_wdata_o;
  logic [255:0] ub_rdata_i;
  logic [255:0] rd_data_o;
  logic         rd_valid_o;
  logic         starve_o;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  logic [11:0] sa0 = '0;
  logic [11:0] sa1 = '0;

  unified_buffer_port_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .wb_valid_i  (wb_valid_i),
    .wb_last_i   (wb_last_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .wb_ready_o  (wb_ready_o),
    .host_valid_i(host_valid_i),
    .host_last_i (host_last_i),
    .host_addr_i (host_addr_i),
    .host_data_i (host_data_i),
    .host_ready_o(host_ready_o),
    .ub_en_o     (ub_en_o),
    .ub_we_o     (ub_we_o),
    .ub_addr_o   (ub_addr_o),
    .ub_wdata_o  (ub_wdata_o),
    .ub_rdata_i  (ub_rdata_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .starve_o    (starve_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [255:0] wdat(input logic [11:0] a);
    return {8{20'hB0000, a}};
  endfunction
  function automatic logic [255:0] hdat(input logic [11:0] a);
    return {8{20'hC0000, a}};
  endfunction
  function automatic logic [255:0] rdat(input logic [11:0] a);
    return {8{20'hD0000, a}};
  endfunction

  // SRAM model with two cycles of read latency from the command register.
  always @(posedge clk_i) begin
    sa0 <= ub_addr_o;
    sa1 <= sa0;
  end
  assign ub_rdata_i = rdat(sa1);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk_i) begin
    if (ub_en_o === 1'b1) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_extra", ub_en_o, 1'b0);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        chk("cmd_we", ub_we_o, e.we);
        chk("cmd_addr", ub_addr_o, e.addr);
        chk("cmd_cyc", cyc, e.cyc);
        if (e.we) chk("cmd_data", ub_wdata_o, e.data);
      end
    end
    if (rd_valid_o === 1'b1) begin
      if (rd_q.size() == 0) begin
        chk("rd_extra", rd_valid_o, 1'b0);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_data", rd_data_o, r.data);
        chk("rd_cyc", cyc, r.cyc);
      end
    end
  end

  task automatic step(input logic rd, input logic [11:0] ra,
                      input logic wv, input logic wl, input logic [11:0] wa,
                      input logic hv, input logic hl, input logic [11:0] ha,
                      input ub_req_e exp_g);
    rd_en_i = rd;  rd_addr_i = ra;
    wb_valid_i = wv;  wb_last_i = wl;  wb_addr_i = wa;  wb_data_i = wdat(wa);
    host_valid_i = hv;  host_last_i = hl;  host_addr_i = ha;  host_data_i = hdat(ha);
    #1;
    chk("wb_ready", wb_ready_o, exp_g == UB_REQ_WB);
    chk("host_ready", host_ready_o, exp_g == UB_REQ_HOST);
    case (exp_g)
      UB_REQ_RD: begin
        cmd_q.push_back('{we: 1'b0, addr: ra, data: '0, cyc: cyc + 1});
        rd_q.push_back('{data: rdat(ra), cyc: cyc + RdLat + 1});
      end
      UB_REQ_WB:   cmd_q.push_back('{we: 1'b1, addr: wa, data: wdat(wa), cyc: cyc + 1});
      UB_REQ_HOST: cmd_q.push_back('{we: 1'b1, addr: ha, data: hdat(ha), cyc: cyc + 1});
      default: ;
    endcase
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, UB_REQ_NONE);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    rd_en_i = 1'b0;  wb_valid_i = 1'b0;  host_valid_i = 1'b0;
    wb_last_i = 1'b0;  host_last_i = 1'b0;
    @(posedge clk_i);
    #1;
    rd_q.delete();  // reads in flight at reset are dropped
    chk("rst_en", ub_en_o, 1'b0);
    chk("rst_we", ub_we_o, 1'b0);
    chk("rst_addr", ub_addr_o, '0);
    chk("rst_wdata", ub_wdata_o, '0);
    chk("rst_rd_valid", rd_valid_o, 1'b0);
    chk("rst_rd_data", rd_data_o, '0);
    chk("rst_starve", starve_o, 1'b0);
    chk("rst_wb_ready", wb_ready_o, 1'b0);
    chk("rst_host_ready", host_ready_o, 1'b0);
    rst_i = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (cmd_q.size() != 0 || rd_q.size() != 0); i++) idle();
    chk("drain_cmd", 32'(cmd_q.size()), 32'd0);
    chk("drain_rd", 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset while three reads are in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 12'(12'h100 + i), 0, 0, '0, 0, 0, '0, UB_REQ_RD);
    do_reset();
    idle();
    idle();
    idle();

    // RD only, back-to-back.
    for (int i = 0; i < 8; i++) step(1'b1, 12'(i), 0, 0, '0, 0, 0, '0, UB_REQ_RD);

    // Single-beat WB/HOST contention alternates, WB first.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 12'(12'h30 + i), 1'b1, 1'b1, 12'(12'h40 + i),
           (i % 2 == 0) ? UB_REQ_WB : UB_REQ_HOST);
    end

    // WB burst holds the lock through an RD interruption, then HOST.
    step(1'b0, '0,      1'b1, 1'b0, 12'h010, 1'b1, 1'b1, 12'h020, UB_REQ_WB);
    step(1'b1, 12'h050, 1'b1, 1'b0, 12'h011, 1'b1, 1'b1, 12'h020, UB_REQ_RD);
    step(1'b0, '0,      1'b1, 1'b0, 12'h011, 1'b1, 1'b1, 12'h020, UB_REQ_WB);
    step(1'b0, '0,      1'b1, 1'b0, 12'h012, 1'b1, 1'b1, 12'h020, UB_REQ_WB);
    step(1'b0, '0,      1'b1, 1'b1, 12'h013, 1'b1, 1'b1, 12'h020, UB_REQ_WB);
    step(1'b0, '0,      1'b0, 1'b0, '0,      1'b1, 1'b1, 12'h020, UB_REQ_HOST);

    // Locked writer idles; HOST must wait for the WB last beat.
    step(1'b0, '0, 1'b1, 1'b0, 12'h200, 1'b1, 1'b1, 12'h300, UB_REQ_WB);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 12'h300, UB_REQ_NONE);
    step(1'b0, '0, 1'b1, 1'b1, 12'h201, 1'b1, 1'b1, 12'h300, UB_REQ_WB);
    step(1'b0, '0, 1'b0, 1'b0, '0,      1'b1, 1'b1, 12'h300, UB_REQ_HOST);
    drain();

    // Starvation: HOST blocked by 70 cycles of RD.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 12'(i), 0, 0, '0, 1'b1, 1'b1, 12'h060, UB_REQ_RD);
      chk("starve", starve_o, (i + 1 >= 64));
    end
    step(1'b0, '0, 0, 0, '0, 1'b1, 1'b1, 12'h060, UB_REQ_HOST);
    chk("starve_sticky", starve_o, 1'b1);
    idle();
    chk("starve_sticky2", starve_o, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
